xoodyak_op_sequencer: RTL and testbench
=======================================

Name: xoodyak_op_sequencer

Overview:
Programmable command sequencer that drives the opmode/input_data interface of xoodyak_build from an internal script memory.
It replaces hard-wired per-cycle opmode tables with handshaked stepping: each entry is held until the core reports finished.
It supports configurable script depth and data width, single-shot or looped runs, per-step result capture, and a timeout watchdog.
It sits between a host/bench programming port and xoodyak_build.

Parameters:
DEPTH, 48, script entries (power of 2 not required, >=2)
DATA_W, 352, width of input_data per entry
OP_W, 5, opmode width (0 = idle)
TEXT_W, 192, width of captured core textout
TMO_W, 8, timeout counter width; timeout fires at 2**TMO_W-1 wait cycles

Ports:
eph1  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
prog_we  in  1  write script entry; ignored while busy
prog_addr  in  $clog2(DEPTH)  entry index; writes with addr>=DEPTH are ignored
prog_op  in  OP_W  entry opmode
prog_data  in  DATA_W  entry data
prog_last  in  1  entry terminates the script
start  in  1  begin run from entry 0; honoured only when not busy
abort  in  1  return to IDLE; highest priority after reset
loop_en  in  1  sampled at each last-entry completion; 1 = restart at entry 0
core_finished  in  1  xoodyak_build finished
core_textout  in  TEXT_W  xoodyak_build textout
core_opmode  out  OP_W  to xoodyak_build opmode
core_data  out  DATA_W  to xoodyak_build input_data
busy  out  1  state is RUN or WAIT
done  out  1  one-cycle pulse on script completion without loop
err  out  1  sticky timeout flag; cleared by start or abort
result  out  TEXT_W  core_textout captured at the most recent finished
result_valid  out  1  one-cycle pulse, the cycle after capture
result_idx  out  $clog2(DEPTH)  entry index for result
loop_cnt  out  16  completed passes; wraps at 0xFFFF->0

Behaviour:
- Reset values: every output is 0, FSM=IDLE, ptr=0, timer=0. The script memory is not reset; its contents are undefined until written.
- States: IDLE, RUN, WAIT, DONE, ERR.
- IDLE/DONE/ERR + start: ptr<=0, err<=0, loop_cnt<=0, go to RUN. core_opmode is valid one cycle after start is sampled.
- RUN (1 cycle): register core_opmode/core_data from mem[ptr], clear timer, go to WAIT.
  - If mem[ptr].op==0, skip WAIT and complete the step immediately; no result is captured.
- WAIT: hold core_opmode/core_data stable and increment timer each cycle.
  - On core_finished: result<=core_textout, result_idx<=ptr, result_valid pulses the next cycle, then complete the step.
  - If the timer saturates before finished: err<=1, core_opmode<=0, go to ERR.
  - If finished and timeout occur in the same cycle, finished wins.
- Step completion:
  - If entry.last, or ptr==DEPTH-1 (forced end, no wrap past DEPTH): when loop_en=1, loop_cnt++, ptr<=0, go to RUN; when loop_en=0, done pulses, go to DONE.
  - Otherwise ptr<=ptr+1 and go to RUN.
- In IDLE/DONE/ERR, core_opmode=0 and core_data holds its last value.
- abort in any state: next cycle IDLE, core_opmode=0, err<=0, no done pulse. abort and start in the same cycle: abort wins.
- prog_we while busy: dropped silently. prog_we and start in the same cycle while not busy: the write lands and the run starts, so entry 0 reflects the write if addr==0.
- Deassertion of reset is synchronized by the caller; the block does not add a synchronizer.

Decomposition:
- Package xoodyak_seq_pkg holds:
  - state enum seq_state_t;
  - entry struct {op, data, last};
  - opmode constants OP_IDLE=0, OP_INIT=1, OP_NONCE=2, OP_ASSOC=3, OP_CRYPT=4, OP_DECRYPT=5, OP_SQUEEZE=6, OP_RATCHET=7.
- One sub-module, xoodyak_seq_mem: a DEPTH x (OP_W+DATA_W+1) register file with one write port and one async read port.

Test Plan:
1. Program entries 0..3 = {1,key},{2,nonce},{3,ad},{4 last,pt}; start; model finishes each 3 cycles after opmode -> core_opmode sequence 1,2,3,4 then 0; four result_valid pulses with idx 0..3; done one pulse; busy low.
2. Same script with loop_en=1 for two passes, then loop_en=0 -> loop_cnt=2; opmode sequence repeated 3 times; single done.
3. Core never asserts finished on entry 1 -> err=1 exactly 255 WAIT cycles after entry 1 issue; core_opmode=0; start clears err.
4. Entry 2 op=0 -> that step lasts 1 cycle (RUN only); no result_valid for idx 2; sequence continues at entry 3.
5. abort asserted during WAIT with start the same cycle -> IDLE, no done, no result_valid; prog_we during busy leaves memory unchanged (read back via a later run).
6. Assert reset (0) asynchronously mid-WAIT -> all outputs 0 immediately; after release, start replays the preserved script.

Source files
------------

// File: rtl/xoodyak_seq_pkg.sv
// ----------------------------------------------------------------------------
// xoodyak_seq_pkg
// Shared types and constants for the Xoodyak opmode sequencer.
//   seq_state_t : sequencer FSM state encoding (IDLE is all-zero)
//   seq_entry_t : one script entry {op, data, last} at the default widths
//   OP_*        : opmode codes understood by xoodyak_build (0 = idle)
// ----------------------------------------------------------------------------
package xoodyak_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } seq_state_t;

    localparam int SEQ_OP_W   = 5;
    localparam int SEQ_DATA_W = 352;
    localparam int SEQ_TEXT_W = 192;

    // Field order matches the packing used by the script memory:
    // {op, data, last}, with last in bit 0.
    typedef struct packed {
        logic [SEQ_OP_W-1:0]   op;
        logic [SEQ_DATA_W-1:0] data;
        logic                  last;
    } seq_entry_t;

    localparam logic [SEQ_OP_W-1:0] OP_IDLE    = 5'd0;
    localparam logic [SEQ_OP_W-1:0] OP_INIT    = 5'd1;
    localparam logic [SEQ_OP_W-1:0] OP_NONCE   = 5'd2;
    localparam logic [SEQ_OP_W-1:0] OP_ASSOC   = 5'd3;
    localparam logic [SEQ_OP_W-1:0] OP_CRYPT   = 5'd4;
    localparam logic [SEQ_OP_W-1:0] OP_DECRYPT = 5'd5;
    localparam logic [SEQ_OP_W-1:0] OP_SQUEEZE = 5'd6;
    localparam logic [SEQ_OP_W-1:0] OP_RATCHET = 5'd7;

endpackage

// File: rtl/xoodyak_seq_mem.sv
// ----------------------------------------------------------------------------
// xoodyak_seq_mem
// Script storage: DEPTH x W register file, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
//   clk   : write clock (rising edge)
//   we    : write enable (caller guarantees waddr < DEPTH when set)
//   waddr : write index
//   wdata : packed entry {op, data, last}
//   raddr : read index
//   rdata : entry at raddr, combinational
// ----------------------------------------------------------------------------
module xoodyak_seq_mem
    import xoodyak_seq_pkg::*;
#(
    parameter  int DEPTH  = 48,
    parameter  int W      = 358,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/xoodyak_op_sequencer.sv
// ----------------------------------------------------------------------------
// xoodyak_op_sequencer
// Steps through a programmed script, presenting each entry's opmode/data to
// xoodyak_build and holding it until the core reports finished.
//   eph1, reset      : clock (rising edge), async active-low reset
//   prog_*           : script programming port (ignored while busy)
//   start, abort     : run control (abort beats start)
//   loop_en          : restart at entry 0 when the last entry completes
//   core_finished    : step completion from the core
//   core_textout     : core output, captured into result on finished
//   core_opmode/data : drive to the core; opmode is 0 whenever not running
//   busy, done, err  : status (done is a pulse, err is sticky)
//   result*          : last captured textout, its entry index, valid pulse
//   loop_cnt         : number of looped passes since start
//   dbg_state        : current FSM state
//
// Handshake: an entry is issued when core_opmode/core_data update at the end
// of RUN; they stay stable through WAIT until core_finished is sampled high,
// which completes the step. A step with opmode 0 completes in RUN alone.
// ----------------------------------------------------------------------------
module xoodyak_op_sequencer
    import xoodyak_seq_pkg::*;
#(
    parameter  int DEPTH  = 48,
    parameter  int DATA_W = 352,
    parameter  int OP_W   = 5,
    parameter  int TEXT_W = 192,
    parameter  int TMO_W  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              eph1,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [OP_W-1:0]   prog_op,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic              core_finished,
    input  logic [TEXT_W-1:0] core_textout,
    output logic [OP_W-1:0]   core_opmode,
    output logic [DATA_W-1:0] core_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TEXT_W-1:0] result,
    output logic              result_valid,
    output logic [ADDR_W-1:0] result_idx,
    output logic [15:0]       loop_cnt,
    output seq_state_t        dbg_state
);

    localparam int ENT_W = OP_W + DATA_W + 1;
    // Timer value during the last wait cycle before the timeout fires; the
    // timer counts completed wait cycles, so the timeout lands on wait cycle
    // number 2**TMO_W-1.
    localparam logic [TMO_W-1:0] TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [ADDR_W-1:0] ptr;
    logic [TMO_W-1:0]  timer;

    logic [ENT_W-1:0]  ent;
    logic [OP_W-1:0]   ent_op;
    logic [DATA_W-1:0] ent_data;
    logic              ent_last;
    logic              mem_we;

    logic              idle_like;
    logic              at_end;
    logic              step_done;
    logic              tmo_hit;
    logic              launch;
    logic              wrap;
    logic              finish;
    logic              advance;

    // ------------------------------------------------------------------
    // Script memory
    // ------------------------------------------------------------------
    assign mem_we = prog_we && !busy &&
                    ({1'b0, prog_addr} < (ADDR_W+1)'(DEPTH));

    xoodyak_seq_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .clk   (eph1),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata ({prog_op, prog_data, prog_last}),
        .raddr (ptr),
        .rdata (ent)
    );

    assign ent_op   = ent[ENT_W-1 -: OP_W];
    assign ent_data = ent[DATA_W:1];
    assign ent_last = ent[0];

    // ------------------------------------------------------------------
    // Step decisions shared by the FSM and the datapath
    // ------------------------------------------------------------------
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    // The last slot ends the script even without its last flag.
    assign at_end    = ent_last || (ptr == PTR_LAST);
    // finished beats the timeout when both land in the same cycle.
    assign step_done = !abort &&
                       (((state == ST_RUN) && (ent_op == '0)) ||
                        ((state == ST_WAIT) && core_finished));
    assign tmo_hit   = !abort && (state == ST_WAIT) && !core_finished &&
                       (timer == TMO_LAST);
    assign launch    = !abort && start && idle_like;
    assign wrap      = step_done && at_end && loop_en;
    assign finish    = step_done && at_end && !loop_en;
    assign advance   = step_done && !at_end;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (ent_op == '0) begin
                        state_next = finish ? ST_DONE : ST_RUN;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (core_finished) begin
                        state_next = finish ? ST_DONE : ST_RUN;
                    end else if (tmo_hit) begin
                        state_next = ST_ERR;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs derived from state
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state == ST_RUN) || (state == ST_WAIT);
        dbg_state = state;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            timer        <= '0;
            core_opmode  <= '0;
            core_data    <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            loop_cnt     <= '0;
        end else begin
            done         <= 1'b0;
            result_valid <= 1'b0;
            if (abort) begin
                ptr         <= '0;
                timer       <= '0;
                core_opmode <= '0;
                err         <= 1'b0;
            end else begin
                if (launch) begin
                    ptr      <= '0;
                    err      <= 1'b0;
                    loop_cnt <= '0;
                end
                if (state == ST_RUN) begin
                    core_opmode <= ent_op;
                    core_data   <= ent_data;
                    timer       <= '0;
                end
                if ((state == ST_WAIT) && !core_finished && !tmo_hit) begin
                    timer <= timer + 1'b1;
                end
                if ((state == ST_WAIT) && core_finished) begin
                    result       <= core_textout;
                    result_idx   <= ptr;
                    result_valid <= 1'b1;
                end
                if (tmo_hit) begin
                    err         <= 1'b1;
                    core_opmode <= '0;
                end
                if (advance) begin
                    ptr <= ptr + 1'b1;
                end
                if (wrap) begin
                    ptr      <= '0;
                    loop_cnt <= loop_cnt + 16'd1;
                end
                // Placed last so it overrides the RUN-state opmode load.
                if (finish) begin
                    done        <= 1'b1;
                    core_opmode <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xoodyak_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_xoodyak_op_sequencer
// Directed bench: scripted runs against a small core model; a monitor pops
// expected results and opmode changes from queues as the DUT presents them.
// ----------------------------------------------------------------------------
module tb_xoodyak_op_sequencer;
    import xoodyak_seq_pkg::*;

    localparam int DEPTH  = 48;
    localparam int DATA_W = 352;
    localparam int OP_W   = 5;
    localparam int TEXT_W = 192;
    localparam int TMO_W  = 8;
    localparam int ADDR_W = 6;

    logic              eph1;
    logic              reset;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [OP_W-1:0]   prog_op;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              start;
    logic              abort;
    logic              loop_en;
    logic              core_finished = 1'b0;
    logic [TEXT_W-1:0] core_textout;
    logic [OP_W-1:0]   core_opmode;
    logic [DATA_W-1:0] core_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [TEXT_W-1:0] result;
    logic              result_valid;
    logic [ADDR_W-1:0] result_idx;
    logic [15:0]       loop_cnt;
    seq_state_t        dbg_state;

    xoodyak_op_sequencer #(
        .DEPTH (DEPTH), .DATA_W (DATA_W), .OP_W (OP_W),
        .TEXT_W (TEXT_W), .TMO_W (TMO_W)
    ) dut (
        .eph1 (eph1), .reset (reset),
        .prog_we (prog_we), .prog_addr (prog_addr), .prog_op (prog_op),
        .prog_data (prog_data), .prog_last (prog_last),
        .start (start), .abort (abort), .loop_en (loop_en),
        .core_finished (core_finished), .core_textout (core_textout),
        .core_opmode (core_opmode), .core_data (core_data),
        .busy (busy), .done (done), .err (err),
        .result (result), .result_valid (result_valid), .result_idx (result_idx),
        .loop_cnt (loop_cnt), .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        eph1 = 1'b0;
        forever #5 eph1 = ~eph1;
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [TEXT_W+ADDR_W-1:0] exp_q[$];
    logic [OP_W-1:0]          exp_op_q[$];

    logic [DATA_W-1:0] data_tbl [4];
    logic [OP_W-1:0]   ops      [4];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- core model ----------------
    // Finishes on the third wait cycle; an opmode equal to hang_op never finishes.
    int              wait_cnt = 0;
    logic [OP_W-1:0] hang_op  = 5'd31;

    always @(negedge eph1) begin
        if (dbg_state == ST_WAIT) wait_cnt++;
        else wait_cnt = 0;
        core_finished = (dbg_state == ST_WAIT) && (wait_cnt == 3) && (core_opmode != hang_op);
    end

    assign core_textout = core_data[TEXT_W-1:0] ^ TEXT_W'(core_opmode);

    // ---------------- monitor / scoreboard ----------------
    int              cyc        = 0;
    int              chg_cyc    = 0;
    int              gap_to_4   = -1;
    int              issue2_cyc = 0;
    int              err_cyc    = 0;
    int              done_cnt   = 0;
    logic [OP_W-1:0] prev_op    = '0;
    logic            prev_err   = 1'b0;

    always @(posedge eph1) begin
        #1;
        cyc++;
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: idx %0d text %0h, nothing expected", result_idx, result);
            end else begin
                check("result", {result_idx, result}, exp_q.pop_front());
            end
        end
        if (core_opmode !== prev_op) begin
            if (core_opmode == OP_CRYPT) gap_to_4 = cyc - chg_cyc;
            if (core_opmode == OP_NONCE) issue2_cyc = cyc;
            chg_cyc = cyc;
            if (exp_op_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_opmode: got %0d, nothing expected", core_opmode);
            end else begin
                check("opmode_seq", core_opmode, exp_op_q.pop_front());
            end
            prev_op = core_opmode;
        end
        if (err && !prev_err) err_cyc = cyc;
        prev_err = err;
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic prog(input int addr, input logic [OP_W-1:0] op,
                        input logic [DATA_W-1:0] data, input logic last);
        @(negedge eph1);
        prog_we   = 1'b1;
        prog_addr = ADDR_W'(addr);
        prog_op   = op;
        prog_data = data;
        prog_last = last;
        @(negedge eph1);
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge eph1);
        start = 1'b1;
        @(negedge eph1);
        start = 1'b0;
    endtask

    // Expected opmode changes and results for `passes` runs of the 4-entry
    // script; zero2 means entry 2 carries opmode 0.
    task automatic push_run(input int passes, input bit zero2);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 4; i++) begin
                if (zero2 && i == 2) begin
                    exp_op_q.push_back(OP_IDLE);
                end else begin
                    exp_op_q.push_back(ops[i]);
                    exp_q.push_back({ADDR_W'(i), data_tbl[i][TEXT_W-1:0] ^ TEXT_W'(ops[i])});
                end
            end
        end
        exp_op_q.push_back(OP_IDLE);
    endtask

    task automatic wait_done(input string name, input int bound);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < bound) begin
            @(negedge eph1);
            k++;
        end
        repeat (4) @(negedge eph1);
        check(name, done_cnt - d0, 1);
    endtask

    task automatic wait_op(input string name, input logic [OP_W-1:0] op, input int bound);
        int k = 0;
        while (!(dbg_state == ST_WAIT && core_opmode == op) && k < bound) begin
            @(negedge eph1);
            k++;
        end
        check(name, {dbg_state == ST_WAIT, core_opmode}, {1'b1, op});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int k;
        reset     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_op   = '0;
        prog_data = '0;
        prog_last = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        loop_en   = 1'b0;
        ops[0] = OP_INIT;  data_tbl[0] = {11{32'h0123_4567}};
        ops[1] = OP_NONCE; data_tbl[1] = {11{32'h89AB_CDEF}};
        ops[2] = OP_ASSOC; data_tbl[2] = {11{32'h0F1E_2D3C}};
        ops[3] = OP_CRYPT; data_tbl[3] = {11{32'hDEAD_BEEF}};

        repeat (3) @(negedge eph1);
        check("reset_ctl", {core_opmode, busy, done, err, result_valid, result_idx, loop_cnt, dbg_state}, '0);
        check("reset_data", core_data, '0);
        check("reset_result", result, '0);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) prog(i, ops[i], data_tbl[i], i == 3);

        // 1: single-shot run
        push_run(1, 0);
        pulse_start();
        wait_done("t1_done", 200);
        check("t1_state", dbg_state, ST_DONE);
        check("t1_busy_op", {busy, core_opmode}, '0);
        check("t1_loop_cnt", loop_cnt, 0);
        check("t1_last_result", {result_idx, result}, {6'd3, data_tbl[3][TEXT_W-1:0] ^ 192'd4});

        // 2: two looped passes then a final pass
        loop_en = 1'b1;
        push_run(3, 0);
        pulse_start();
        k = 0;
        while (loop_cnt != 16'd2 && k < 300) begin
            @(negedge eph1);
            k++;
        end
        check("t2_loop_reached", loop_cnt, 2);
        loop_en = 1'b0;
        wait_done("t2_done", 300);
        check("t2_loop_cnt", loop_cnt, 2);

        // 3: core hangs on entry 1 -> timeout
        hang_op = OP_NONCE;
        exp_op_q.push_back(OP_INIT);
        exp_op_q.push_back(OP_NONCE);
        exp_op_q.push_back(OP_IDLE);
        exp_q.push_back({6'd0, data_tbl[0][TEXT_W-1:0] ^ 192'd1});
        d0 = done_cnt;
        pulse_start();
        check("t3_loop_clr", loop_cnt, 0);
        k = 0;
        while (err !== 1'b1 && k < 400) begin
            @(negedge eph1);
            k++;
        end
        check("t3_err", err, 1);
        check("t3_err_delay", err_cyc - issue2_cyc, 255);
        check("t3_state", dbg_state, ST_ERR);
        check("t3_busy_op", {busy, core_opmode}, '0);
        check("t3_no_done", done_cnt - d0, 0);
        hang_op = 5'd31;
        push_run(1, 0);
        pulse_start();
        check("t3_err_clr", err, 0);
        wait_done("t3_rerun_done", 200);

        // 4: entry 2 with opmode 0 completes in RUN alone
        prog(2, OP_IDLE, data_tbl[2], 1'b0);
        gap_to_4 = -1;
        push_run(1, 1);
        pulse_start();
        wait_done("t4_done", 200);
        check("t4_skip_gap", gap_to_4, 1);
        prog(2, ops[2], data_tbl[2], 1'b0);

        // 5: abort + start together during WAIT; write while busy is dropped
        exp_op_q.push_back(OP_INIT);
        exp_op_q.push_back(OP_NONCE);
        exp_op_q.push_back(OP_IDLE);
        exp_q.push_back({6'd0, data_tbl[0][TEXT_W-1:0] ^ 192'd1});
        pulse_start();
        wait_op("t5_reach_wait", OP_NONCE, 100);
        d0 = done_cnt;
        @(negedge eph1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge eph1);
        abort = 1'b0;
        start = 1'b0;
        check("t5_abort_state", dbg_state, ST_IDLE);
        check("t5_abort_busy_op", {busy, core_opmode, err}, '0);
        repeat (6) @(negedge eph1);
        check("t5_still_idle", dbg_state, ST_IDLE);
        check("t5_no_done", done_cnt - d0, 0);
        push_run(1, 0);
        pulse_start();
        prog(3, OP_RATCHET, {11{32'h7777_7777}}, 1'b1);
        wait_done("t5_run_a", 200);
        push_run(1, 0);
        pulse_start();
        wait_done("t5_run_b", 200);

        // 6: async reset mid-WAIT, script survives
        exp_op_q.push_back(OP_INIT);
        exp_op_q.push_back(OP_NONCE);
        exp_op_q.push_back(OP_ASSOC);
        exp_op_q.push_back(OP_IDLE);
        exp_q.push_back({6'd0, data_tbl[0][TEXT_W-1:0] ^ 192'd1});
        exp_q.push_back({6'd1, data_tbl[1][TEXT_W-1:0] ^ 192'd2});
        pulse_start();
        wait_op("t6_reach_wait", OP_ASSOC, 100);
        @(negedge eph1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_reset_ctl", {core_opmode, busy, done, err, result_valid, result_idx, loop_cnt, dbg_state}, '0);
        check("t6_reset_data", core_data, '0);
        check("t6_reset_result", result, '0);
        repeat (2) @(negedge eph1);
        reset = 1'b1;
        push_run(1, 0);
        pulse_start();
        wait_done("t6_replay_done", 200);

        repeat (3) @(negedge eph1);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_op_q_drained", exp_op_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
